// File: rtl/jtag_ir_pkg.sv
// ============================================================================
// jtag_ir_pkg : opcode, select-index and helper definitions for the JTAG IR
// Rev 1.0
// ============================================================================
`default_nettype none

package jtag_ir_pkg;

  localparam int c_OP_W = 4;

  localparam logic [c_OP_W-1:0] c_OP_SAMPLE   = 4'h1;
  localparam logic [c_OP_W-1:0] c_OP_EXTEST   = 4'h2;
  localparam logic [c_OP_W-1:0] c_OP_INTEST   = 4'h3;
  localparam logic [c_OP_W-1:0] c_OP_RUNBIST  = 4'h4;
  localparam logic [c_OP_W-1:0] c_OP_CLAMP    = 4'h5;
  localparam logic [c_OP_W-1:0] c_OP_IDCODE   = 4'h7;
  localparam logic [c_OP_W-1:0] c_OP_USERCODE = 4'h8;
  localparam logic [c_OP_W-1:0] c_OP_HIGHZ    = 4'h9;

  localparam int c_SEL_W        = 9;
  localparam int c_SEL_BYPASS   = 0;
  localparam int c_SEL_SAMPLE   = 1;
  localparam int c_SEL_EXTEST   = 2;
  localparam int c_SEL_INTEST   = 3;
  localparam int c_SEL_RUNBIST  = 4;
  localparam int c_SEL_CLAMP    = 5;
  localparam int c_SEL_IDCODE   = 6;
  localparam int c_SEL_USERCODE = 7;
  localparam int c_SEL_HIGHZ    = 8;

  localparam int c_IR_W_MAX = 8;

  // All-ones opcode in the low ir_w bits; callers truncate to their IR width.
  function automatic logic [c_IR_W_MAX-1:0] bypass_code(input int ir_w);
    logic [c_IR_W_MAX-1:0] code;
    code = '0;
    for (int i = 0; i < c_IR_W_MAX; i++) begin
      if (i < ir_w) code[i] = 1'b1;
    end
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_ir_decode.sv
// ============================================================================
// jtag_ir_decode : one-hot data-register select from the latched instruction
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_ir_decode
  import jtag_ir_pkg::*;
#(
  parameter int IR_W = 4
) (
  input  logic [IR_W-1:0]    LATCH_JTAG_IR,
  output logic [c_SEL_W-1:0] SEL
);

  localparam logic [IR_W-1:0] c_BYPASS   = IR_W'(bypass_code(IR_W));
  localparam logic [IR_W-1:0] c_SAMPLE   = IR_W'(c_OP_SAMPLE);
  localparam logic [IR_W-1:0] c_EXTEST   = IR_W'(c_OP_EXTEST);
  localparam logic [IR_W-1:0] c_INTEST   = IR_W'(c_OP_INTEST);
  localparam logic [IR_W-1:0] c_RUNBIST  = IR_W'(c_OP_RUNBIST);
  localparam logic [IR_W-1:0] c_CLAMP    = IR_W'(c_OP_CLAMP);
  localparam logic [IR_W-1:0] c_IDCODE   = IR_W'(c_OP_IDCODE);
  localparam logic [IR_W-1:0] c_USERCODE = IR_W'(c_OP_USERCODE);
  localparam logic [IR_W-1:0] c_HIGHZ    = IR_W'(c_OP_HIGHZ);

  // Unassigned opcodes fall through to BYPASS so exactly one select is high.
  always_comb begin
    SEL = '0;
    case (LATCH_JTAG_IR)
      c_SAMPLE:   SEL[c_SEL_SAMPLE]   = 1'b1;
      c_EXTEST:   SEL[c_SEL_EXTEST]   = 1'b1;
      c_INTEST:   SEL[c_SEL_INTEST]   = 1'b1;
      c_RUNBIST:  SEL[c_SEL_RUNBIST]  = 1'b1;
      c_CLAMP:    SEL[c_SEL_CLAMP]    = 1'b1;
      c_IDCODE:   SEL[c_SEL_IDCODE]   = 1'b1;
      c_USERCODE: SEL[c_SEL_USERCODE] = 1'b1;
      c_HIGHZ:    SEL[c_SEL_HIGHZ]    = 1'b1;
      c_BYPASS:   SEL[c_SEL_BYPASS]   = 1'b1;
      default:    SEL[c_SEL_BYPASS]   = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/jtag_ir_param.sv
// ============================================================================
// jtag_ir_param : parametrised JTAG instruction register with short-shift guard
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_ir_param
  import jtag_ir_pkg::*;
#(
  parameter int              IR_W        = 4,
  parameter logic [IR_W-1:0] RESET_INSTR = IR_W'(c_OP_IDCODE),
  parameter bit              LEN_CHECK   = 1'b1
) (
  input  logic               CLOCKIR,
  input  logic               TRST,
  input  logic               TDI,
  input  logic               CAPTUREIR,
  input  logic               SHIFTIR,
  input  logic               UPDATEIR,
  input  logic [IR_W-3:0]    CAPTURE_STATUS,
  output logic               INSTR_TDO,
  output logic [IR_W-1:0]    LATCH_JTAG_IR,
  output logic [c_SEL_W-1:0] SEL,
  output logic               UPDATE_ERR
);

  localparam int                 c_CNT_W    = $clog2(IR_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(IR_W);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [IR_W-1:0]    r_sr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [IR_W-1:0]    r_latch;
  logic               r_tdo;
  logic               r_err;

  logic w_cnt_full;
  logic w_len_ok;
  logic w_update;

  assign w_cnt_full = (r_cnt == c_CNT_FULL);
  assign w_len_ok   = !LEN_CHECK || w_cnt_full;
  assign w_update   = UPDATEIR && !CAPTUREIR && !SHIFTIR;

  // Counter saturates so any over-shift still qualifies as a full-length scan.
  always_ff @(posedge CLOCKIR or posedge TRST) begin
    if (TRST) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (CAPTUREIR) begin
      r_sr  <= {CAPTURE_STATUS, 2'b01};
      r_cnt <= '0;
    end else if (SHIFTIR) begin
      r_sr <= {TDI, r_sr[IR_W-1:1]};
      if (!w_cnt_full) r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  always_ff @(posedge CLOCKIR or posedge TRST) begin
    if (TRST) begin
      r_latch <= RESET_INSTR;
      r_err   <= 1'b0;
    end else if (w_update) begin
      if (w_len_ok) begin
        r_latch <= r_sr;
        r_err   <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(negedge CLOCKIR or posedge TRST) begin
    if (TRST) r_tdo <= 1'b1;
    else      r_tdo <= r_sr[0];
  end

  jtag_ir_decode #(
    .IR_W (IR_W)
  ) u_decode (
    .LATCH_JTAG_IR (r_latch),
    .SEL           (SEL)
  );

  assign INSTR_TDO     = r_tdo;
  assign LATCH_JTAG_IR = r_latch;
  assign UPDATE_ERR    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_jtag_ir_param.sv
// ============================================================================
// tb_jtag_ir_param : directed vector bench for jtag_ir_param (IR_W 4 and 6)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jtag_ir_param;

  logic clk;

  logic       a_trst, a_cap, a_sh, a_upd, a_tdi;
  logic [1:0] a_status;
  logic       a_tdo, c_tdo, a_err, c_err;
  logic [3:0] a_latch, c_latch;
  logic [8:0] a_sel, c_sel;

  logic       b_trst, b_cap, b_sh, b_upd, b_tdi;
  logic [3:0] b_status;
  logic       b_tdo, b_err;
  logic [5:0] b_latch;
  logic [8:0] b_sel;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_ir_param #(.IR_W(4)) u_a (
    .CLOCKIR(clk), .TRST(a_trst), .TDI(a_tdi), .CAPTUREIR(a_cap),
    .SHIFTIR(a_sh), .UPDATEIR(a_upd), .CAPTURE_STATUS(a_status),
    .INSTR_TDO(a_tdo), .LATCH_JTAG_IR(a_latch), .SEL(a_sel), .UPDATE_ERR(a_err)
  );

  jtag_ir_param #(.IR_W(4), .LEN_CHECK(1'b0)) u_c (
    .CLOCKIR(clk), .TRST(a_trst), .TDI(a_tdi), .CAPTUREIR(a_cap),
    .SHIFTIR(a_sh), .UPDATEIR(a_upd), .CAPTURE_STATUS(a_status),
    .INSTR_TDO(c_tdo), .LATCH_JTAG_IR(c_latch), .SEL(c_sel), .UPDATE_ERR(c_err)
  );

  jtag_ir_param #(.IR_W(6), .RESET_INSTR(6'h07)) u_b (
    .CLOCKIR(clk), .TRST(b_trst), .TDI(b_tdi), .CAPTUREIR(b_cap),
    .SHIFTIR(b_sh), .UPDATEIR(b_upd), .CAPTURE_STATUS(b_status),
    .INSTR_TDO(b_tdo), .LATCH_JTAG_IR(b_latch), .SEL(b_sel), .UPDATE_ERR(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       trst, cap, sh, upd, tdi;
    logic [1:0] status;
    logic       tdo;
    logic [3:0] latch;
    logic [8:0] sel;
    logic       err;
    logic [3:0] c_latch;
    logic       c_err;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic trst, cap, sh, upd, tdi, input logic [1:0] st,
                              input logic tdo, input logic [3:0] latch, input logic [8:0] sel,
                              input logic err, input logic [3:0] cl, input logic ce);
    vec_t v;
    v.trst = trst; v.cap = cap; v.sh = sh; v.upd = upd; v.tdi = tdi; v.status = st;
    v.tdo = tdo; v.latch = latch; v.sel = sel; v.err = err; v.c_latch = cl; v.c_err = ce;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after a negedge; outputs are settled on return.
  task automatic tick_a(input logic trst, cap, sh, upd, tdi, input logic [1:0] st);
    a_trst = trst; a_cap = cap; a_sh = sh; a_upd = upd; a_tdi = tdi; a_status = st;
    @(posedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic tick_b(input logic trst, cap, sh, upd, tdi, input logic [3:0] st);
    b_trst = trst; b_cap = cap; b_sh = sh; b_upd = upd; b_tdi = tdi; b_status = st;
    @(posedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic load_b(input logic [5:0] v);
    tick_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 6; i++) tick_b(1'b0, 1'b0, 1'b1, 1'b0, v[i], 4'h0);
    tick_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    logic [5:0] exp_seq;

    a_trst = 1'b1; a_cap = 1'b0; a_sh = 1'b0; a_upd = 1'b0; a_tdi = 1'b0; a_status = 2'b00;
    b_trst = 1'b1; b_cap = 1'b0; b_sh = 1'b0; b_upd = 1'b0; b_tdi = 1'b0; b_status = 4'h0;

    //            trst cap sh upd tdi st     tdo latch sel     err  cl   ce
    vecs[0]  = mk(1, 0, 0, 0, 0, 2'd0,  1, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 2'd0,  0, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 2'd2,  1, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[3]  = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 2'd0,  0, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[5]  = mk(0, 0, 1, 0, 1, 2'd0,  1, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0, 2'd0,  1, 4'h7, 9'h040, 0, 4'h7, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 2'd0,  1, 4'h5, 9'h020, 0, 4'h5, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 2'd0,  1, 4'h5, 9'h020, 0, 4'h5, 0);
    vecs[9]  = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'h5, 9'h020, 0, 4'h5, 0);
    vecs[10] = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'h5, 9'h020, 0, 4'h5, 0);
    vecs[11] = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'h5, 9'h020, 0, 4'h5, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 2'd0,  0, 4'h5, 9'h020, 1, 4'hE, 0);
    vecs[13] = mk(0, 1, 0, 0, 0, 2'd3,  1, 4'h5, 9'h020, 1, 4'hE, 0);
    vecs[14] = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'h5, 9'h020, 1, 4'hE, 0);
    vecs[15] = mk(0, 0, 1, 0, 1, 2'd0,  1, 4'h5, 9'h020, 1, 4'hE, 0);
    vecs[16] = mk(0, 0, 1, 0, 1, 2'd0,  1, 4'h5, 9'h020, 1, 4'hE, 0);
    vecs[17] = mk(0, 0, 1, 0, 1, 2'd0,  1, 4'h5, 9'h020, 1, 4'hE, 0);
    vecs[18] = mk(0, 0, 0, 1, 0, 2'd0,  1, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 2'd0,  1, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[20] = mk(0, 1, 0, 0, 0, 2'd0,  1, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[21] = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[22] = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[23] = mk(0, 0, 1, 0, 0, 2'd0,  0, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[24] = mk(0, 0, 1, 0, 1, 2'd0,  1, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[25] = mk(0, 0, 1, 0, 0, 2'd0,  1, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[26] = mk(0, 0, 1, 0, 1, 2'd0,  0, 4'hF, 9'h001, 0, 4'hF, 0);
    vecs[27] = mk(0, 0, 0, 1, 0, 2'd0,  0, 4'hA, 9'h001, 0, 4'hA, 0);
    vecs[28] = mk(0, 1, 0, 1, 0, 2'd1,  1, 4'hA, 9'h001, 0, 4'hA, 0);
    vecs[29] = mk(0, 0, 1, 1, 0, 2'd0,  0, 4'hA, 9'h001, 0, 4'hA, 0);
    vecs[30] = mk(0, 0, 0, 1, 0, 2'd0,  0, 4'hA, 9'h001, 1, 4'h2, 0);

    @(negedge clk); #1;

    for (int i = 0; i < 31; i++) begin
      tick_a(vecs[i].trst, vecs[i].cap, vecs[i].sh, vecs[i].upd, vecs[i].tdi, vecs[i].status);
      chk($sformatf("v%0d tdo", i),     32'(a_tdo),   32'(vecs[i].tdo));
      chk($sformatf("v%0d latch", i),   32'(a_latch), 32'(vecs[i].latch));
      chk($sformatf("v%0d sel", i),     32'(a_sel),   32'(vecs[i].sel));
      chk($sformatf("v%0d err", i),     32'(a_err),   32'(vecs[i].err));
      chk($sformatf("v%0d c_tdo", i),   32'(c_tdo),   32'(vecs[i].tdo));
      chk($sformatf("v%0d c_latch", i), 32'(c_latch), 32'(vecs[i].c_latch));
      chk($sformatf("v%0d c_err", i),   32'(c_err),   32'(vecs[i].c_err));
    end

    // TRST mid-shift: checked between clock edges to prove it is asynchronous.
    tick_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    tick_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    a_trst = 1'b1; a_sh = 1'b0;
    #1;
    chk("trst_async latch",   32'(a_latch), 32'h7);
    chk("trst_async sel",     32'(a_sel),   32'h040);
    chk("trst_async tdo",     32'(a_tdo),   32'h1);
    chk("trst_async err",     32'(a_err),   32'h0);
    chk("trst_async c_latch", 32'(c_latch), 32'h7);
    @(negedge clk); #1;
    tick_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("post_trst tdo", 32'(a_tdo), 32'h0);
    tick_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk("nocap_upd latch", 32'(a_latch), 32'h7);
    chk("nocap_upd sel",   32'(a_sel),   32'h040);
    chk("nocap_upd err",   32'(a_err),   32'h1);
    chk("nocap_upd c_latch", 32'(c_latch), 32'h0);
    chk("nocap_upd c_sel",   32'(c_sel),   32'h001);
    chk("nocap_upd c_err",   32'(c_err),   32'h0);
    tick_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // IR_W = 6 instance.
    tick_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("b_reset latch", 32'(b_latch), 32'h07);
    chk("b_reset sel",   32'(b_sel),   32'h040);
    chk("b_reset tdo",   32'(b_tdo),   32'h1);
    chk("b_reset err",   32'(b_err),   32'h0);
    tick_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    load_b(6'h3F);
    chk("b_3f latch", 32'(b_latch), 32'h3F);
    chk("b_3f sel",   32'(b_sel),   32'h001);
    chk("b_3f err",   32'(b_err),   32'h0);

    load_b(6'h08);
    chk("b_08 latch", 32'(b_latch), 32'h08);
    chk("b_08 sel",   32'(b_sel),   32'h080);

    tick_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) tick_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    tick_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("b_short latch", 32'(b_latch), 32'h08);
    chk("b_short err",   32'(b_err),   32'h1);

    exp_seq = 6'b110001;
    tick_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC);
    chk("b_cap tdo0", 32'(b_tdo), 32'(exp_seq[0]));
    for (int i = 1; i < 6; i++) begin
      tick_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      chk($sformatf("b_cap tdo%0d", i), 32'(b_tdo), 32'(exp_seq[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jtag_ir_param.md
# jtag_ir_param

Parametrised JTAG instruction register for the TAP core. Width, reset instruction and capture pattern are configurable. An IR_W-bit shift stage captures the IEEE 1149.1 "01" pattern plus device status, shifts TDI toward TDO, and transfers to a shadow (latched) instruction on Update-IR. The block adds a short-shift guard: a truncated scan cannot load a partial opcode. The latched instruction is decoded into one-hot select lines for the boundary-scan, ID and bypass data registers.

## Interface
Parameters:
- IR_W, 4: instruction length in bits; legal range 4..8.
- RESET_INSTR, IDCODE opcode zero-extended to IR_W: shadow value after TRST.
- LEN_CHECK, 1: 1 enables the short-shift guard; 0 accepts every update.

Ports:
- CLOCKIR  in  1  free-running TCK supplied by the TAP; never gated. All flops use posedge, except the TDO flop, which uses negedge.
- TRST  in  1  asynchronous, active-high reset.
- TDI  in  1  serial data in.
- CAPTUREIR  in  1  Capture-IR state enable.
- SHIFTIR  in  1  Shift-IR state enable.
- UPDATEIR  in  1  Update-IR state enable.
- CAPTURE_STATUS  in  IR_W-2  device status captured into bits [IR_W-1:2].
- INSTR_TDO  out  1  serial instruction out.
- LATCH_JTAG_IR  out  IR_W  active (shadow) instruction.
- SEL  out  9  one-hot decode, in this order: {HIGHZ, USERCODE, IDCODE, CLAMP, RUNBIST, INTEST, EXTEST, SAMPLE, BYPASS}, bit 0 = BYPASS.
- UPDATE_ERR  out  1  sticky flag: last Update-IR was rejected.

## Operation
- Reset values while TRST is high:
  - shift register = 0;
  - LATCH_JTAG_IR = RESET_INSTR;
  - INSTR_TDO = 1;
  - shift count = 0;
  - UPDATE_ERR = 0;
  - SEL = decode of RESET_INSTR, i.e. IDCODE bit set.
- Enable priority when more than one is high: CAPTUREIR > SHIFTIR > UPDATEIR.
- Capture: shift register <= {CAPTURE_STATUS, 2'b01}; shift count <= 0.
- Shift: shift register <= {TDI, sr[IR_W-1:1]}, LSB first out. Shift count increments and saturates at IR_W.
- Update:
  - Accepted if LEN_CHECK = 0 or shift count = IR_W. Then LATCH_JTAG_IR <= shift register and UPDATE_ERR <= 0.
  - Otherwise LATCH_JTAG_IR holds its value and UPDATE_ERR <= 1.
  - Shifting more than IR_W bits is legal: the last IR_W bits are loaded.
- Decode is combinational from LATCH_JTAG_IR:
  - opcodes SAMPLE 1, EXTEST 2, INTEST 3, RUNBIST 4, CLAMP 5, IDCODE 7, USERCODE 8, HIGHZ 9, zero-extended to IR_W;
  - BYPASS = all ones;
  - any other code sets SEL[0] (BYPASS);
  - exactly one SEL bit is high at all times.
- No enable asserted: all state holds.
- TRST asserted mid-shift: immediate asynchronous return to reset values. A subsequent update without a new capture is rejected when LEN_CHECK = 1, because the count is 0.

## Timing
- Capture, shift and update each take effect on the posedge of CLOCKIR where the enable is sampled high.
- INSTR_TDO is updated on the following negedge with sr[0]. First TDO bit after capture = 1 (pattern LSB), valid one half-cycle after the capture edge.
- LATCH_JTAG_IR and SEL change on the posedge sampling UPDATEIR, zero cycles of pipeline.
- UPDATE_ERR is set or cleared on the same edge as the update decision.
- TRST deassertion is synchronous to CLOCKIR as supplied by the TAP controller. No operation is required on the deasserting edge.

## Structure
- Package jtag_ir_pkg holds:
  - the opcode constants listed above (4-bit base values; zero-extension is done at use);
  - SEL bit index constants;
  - function bypass_code(IR_W) returning all ones.
- Sub-module jtag_ir_decode: pure combinational, LATCH_JTAG_IR to SEL, with default to BYPASS.
- The top holds the shift register, shift counter, shadow register, TDO flop and error flag.

## Test plan
- Reset: pulse TRST, IR_W=4 → LATCH_JTAG_IR=4'h7, SEL=9'b001000000, INSTR_TDO=1, UPDATE_ERR=0.
- Capture plus 4 shifts, CAPTURE_STATUS=2'b10 → TDO sequence 1,0,0,1. TDI bits 1,0,1,0 then update → LATCH_JTAG_IR=4'h5, CLAMP select only.
- Short shift, LEN_CHECK=1: capture, 3 shifts, update → LATCH_JTAG_IR unchanged, UPDATE_ERR=1. A following full 4-bit load of 4'hF → accepted, UPDATE_ERR=0, BYPASS selected.
- Over-shift and undefined code: 6 shifts where the last 4 TDI bits form 4'hA, then update → LATCH_JTAG_IR=4'hA, SEL=9'b000000001.
- IR_W=6, RESET_INSTR=6'h07 → reset decode IDCODE. Loading 6'h3F → BYPASS. Loading 6'h08 → USERCODE. Capture of status 4'hC → TDO 1,0,0,0,1,1.
- TRST asserted after 2 shift bits → immediate reset values. A later update without capture → rejected, UPDATE_ERR=1. Simultaneous CAPTUREIR+UPDATEIR → capture wins, shadow unchanged.
